// File: rtl/frame_compositor.sv
// VGA timing generator with frame-coherent datagram commit and an N-layer
// opaque priority compositor aligned to the layer generators' latency.
module frame_compositor #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned PIXEL_W    = 12,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pix_en,
  input  logic [DATA_W-1:0]               datagram_in,
  input  logic                            datagram_valid,
  input  logic [NUM_LAYERS-1:0]           layer_mask_in,
  output logic [9:0]                      h_cnt,
  output logic [9:0]                      v_cnt,
  output logic [DATA_W-1:0]               frame_data,
  output logic                            frame_tick,
  input  logic [NUM_LAYERS-1:0]           layer_valid,
  input  logic [NUM_LAYERS*PIXEL_W-1:0]   layer_pixel,
  input  logic [PIXEL_W-1:0]              bg_pixel,
  output logic [PIXEL_W-1:0]              rgb,
  output logic                            hsync,
  output logic                            vsync
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam int unsigned LAST    = PIPE_LAT - 1;

  logic [NUM_LAYERS-1:0] mask;
  logic [NUM_LAYERS-1:0] shadow_mask;
  logic [NUM_LAYERS-1:0] opaque_c;
  logic [DATA_W-1:0]     shadow_data;
  logic                  pending;
  logic [PIPE_LAT-1:0]   act_q;
  logic [PIPE_LAT-1:0]   hs_q;
  logic [PIPE_LAT-1:0]   vs_q;
  logic                  act_c;
  logic                  hs_c;
  logic                  vs_c;
  logic                  commit_c;
  logic [PIXEL_W-1:0]    pix_c;

  assign act_c    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_c     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
  assign vs_c     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
  assign commit_c = pix_en && (h_cnt == 10'd0) && (v_cnt == V_ACT);
  assign opaque_c = layer_valid & mask;

  // Raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Datagram shadow and commit at the start of vertical blanking; a datagram
  // arriving on the commit clock itself takes effect immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_data <= '0;
      shadow_mask <= '1;
      pending     <= 1'b0;
      frame_data  <= '0;
      mask        <= '1;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (commit_c) begin
        if (datagram_valid) begin
          frame_data <= datagram_in;
          mask       <= layer_mask_in;
          frame_tick <= 1'b1;
          pending    <= 1'b0;
        end else if (pending) begin
          frame_data <= shadow_data;
          mask       <= shadow_mask;
          frame_tick <= 1'b1;
          pending    <= 1'b0;
        end
      end else if (datagram_valid) begin
        shadow_data <= datagram_in;
        shadow_mask <= layer_mask_in;
        pending     <= 1'b1;
      end
    end
  end

  // Delay active/syncs to line up with the layer generators' output
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= '0;
      hs_q  <= '1;
      vs_q  <= '1;
    end else if (pix_en) begin
      act_q <= PIPE_LAT'({act_q, act_c});
      hs_q  <= PIPE_LAT'({hs_q, hs_c});
      vs_q  <= PIPE_LAT'({vs_q, vs_c});
    end
  end

  // Lowest-index opaque, enabled layer wins; background otherwise
  always_comb begin
    pix_c = bg_pixel;
    for (int k = int'(NUM_LAYERS) - 1; k >= 0; k--) begin
      if (opaque_c[k]) pix_c = layer_pixel[k*PIXEL_W +: PIXEL_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      rgb   <= act_q[LAST] ? pix_c : '0;
      hsync <= hs_q[LAST];
      vsync <= vs_q[LAST];
    end
  end

endmodule
